// File: rtl/norz_alu_pkg.sv
// Shared types for the register-pair ALU operand sequencer.
// Pair and mode codes match the request field encodings. The request struct
// is what the sequencer latches on a handshake. The helpers decide when a
// bus really carries an operand and when a request runs as two byte steps.
package norz_alu_pkg;

   localparam int STEP_CNT_W = 4;

   typedef enum logic [1:0] {
      PAIR_NONE = 2'd0,
      PAIR_BC   = 2'd1,
      PAIR_DE   = 2'd2,
      PAIR_HL   = 2'd3
   } pair_t;

   typedef enum logic [1:0] {
      MODE_NONE  = 2'd0,
      MODE_UPPER = 2'd1,
      MODE_LOWER = 2'd2,
      MODE_PAIR  = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STEP_A = 2'd1,
      ST_STEP_B = 2'd2
   } state_t;

   // Phase the bus decoders see:
   //   PH_FULL - an unsplit step.
   //   PH_LOW  - the low-byte half of a split op.
   //   PH_HIGH - the high-byte half of a split op.
   typedef enum logic [1:0] {
      PH_IDLE = 2'd0,
      PH_FULL = 2'd1,
      PH_LOW  = 2'd2,
      PH_HIGH = 2'd3
   } phase_t;

   typedef struct packed {
      pair_t hi_pair;
      mode_t hi_mode;
      pair_t lo_pair;
      mode_t lo_mode;
      logic  split;
      logic  carry_in;
   } op_req_t;

   // A bus with no source pair carries nothing, whatever its mode says.
   function automatic mode_t eff_mode(input pair_t p, input mode_t m);
      return (p == PAIR_NONE) ? MODE_NONE : m;
   endfunction

   function automatic logic has_pair_mode(input op_req_t r);
      return (eff_mode(r.hi_pair, r.hi_mode) == MODE_PAIR) ||
             (eff_mode(r.lo_pair, r.lo_mode) == MODE_PAIR);
   endfunction

   function automatic logic split_active(input op_req_t r);
      return r.split && has_pair_mode(r);
   endfunction

endpackage

// File: rtl/alu_pair_select_decode.sv
// Combinational select decode for one ALU input bus (High or Low).
// Ports:
//   pair      - source pair (none/BC/DE/HL)
//   mode      - requested mode (none/upper/lower/pair)
//   phase     - which step is being decoded (idle/full/low/high)
//   not_sel_u - [HL,DE,BC] active-low upper-register selects
//   sel_l     - [HL,DE,BC] active-high lower-register selects
//   sel_p     - [HL,DE,BC] active-high full-pair selects
// Only the addressed pair can ever be active. This guarantees that no two
// pairs drive the same bus.
module alu_pair_select_decode
   import norz_alu_pkg::*;
(
   input  pair_t      pair,
   input  mode_t      mode,
   input  phase_t     phase,
   output logic [2:0] not_sel_u,
   output logic [2:0] sel_l,
   output logic [2:0] sel_p
);

   logic [2:0] onehot;
   logic       drv_u, drv_l, drv_p;

   always_comb begin
      case (pair)
         PAIR_BC: onehot = 3'b001;
         PAIR_DE: onehot = 3'b010;
         PAIR_HL: onehot = 3'b100;
         default: onehot = 3'b000;
      endcase

      drv_u = 1'b0;
      drv_l = 1'b0;
      drv_p = 1'b0;
      case (phase)
         PH_FULL: begin
            drv_u = (mode == MODE_UPPER) || (mode == MODE_PAIR);
            drv_l = (mode == MODE_LOWER) || (mode == MODE_PAIR);
            drv_p = (mode == MODE_PAIR);
         end
         // Low half of a split: the pair operand contributes only its lower byte.
         PH_LOW: begin
            drv_u = (mode == MODE_UPPER);
            drv_l = (mode == MODE_LOWER) || (mode == MODE_PAIR);
         end
         // High half: only pair operands take part, via their upper byte.
         PH_HIGH: drv_u = (mode == MODE_PAIR);
         default: ;
      endcase

      not_sel_u = ~(onehot & {3{drv_u}});
      sel_l     = onehot & {3{drv_l}};
      sel_p     = onehot & {3{drv_p}};
   end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Sequences the BC/DE/HL ALU input-mux selects for one operand request at a time.
// Ports:
//   CLK, RESET                - clock; synchronous active-high reset
//   req_valid/req_ready       - request handshake; ready only while idle
//   req_hi_*/req_lo_*         - pair and mode for the High and Low buses
//   req_split, req_carry_in   - byte-split 16-bit op; carry into the first step
//   alu_carry_out             - ALU carry, taken at the end of the low step
//   alu_carry_in              - carry presented during the current step
//   notSel_U_*/Sel_L_*/Sel_P_* - registered per-pair selects for each bus
//   wb_lo, wb_hi              - write-back strobes in a step's final cycle
//   busy                      - not idle
// The selects are decoded from next-state values and then registered.
// Because of this they change only on the edges that enter or leave a step.
module alu_operand_sequencer
   import norz_alu_pkg::*;
#(
   parameter int STEP_CYCLES = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_hi_pair,
   input  logic [1:0] req_hi_mode,
   input  logic [1:0] req_lo_pair,
   input  logic [1:0] req_lo_mode,
   input  logic       req_split,
   input  logic       req_carry_in,
   input  logic       alu_carry_out,
   output logic       alu_carry_in,
   output logic [2:0] notSel_U_hi,
   output logic [2:0] Sel_L_hi,
   output logic [2:0] Sel_P_hi,
   output logic [2:0] notSel_U_lo,
   output logic [2:0] Sel_L_lo,
   output logic [2:0] Sel_P_lo,
   output logic       wb_lo,
   output logic       wb_hi,
   output logic       busy
);

   localparam logic [STEP_CNT_W-1:0] CNT_LOAD = STEP_CNT_W'(STEP_CYCLES - 1);

   state_t                state_q, state_d;
   logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
   op_req_t               req_q, req_d, req_in;
   logic                  carry_hold_q, carry_hold_d;
   phase_t                phase_d;
   logic                  last_cycle, split_q;
   logic [2:0]            nsu_hi_d, sl_hi_d, sp_hi_d, nsu_lo_d, sl_lo_d, sp_lo_d;

   assign last_cycle = (cnt_q == '0);
   assign split_q    = split_active(req_q);

   always_comb begin
      req_in.hi_pair  = pair_t'(req_hi_pair);
      req_in.hi_mode  = mode_t'(req_hi_mode);
      req_in.lo_pair  = pair_t'(req_lo_pair);
      req_in.lo_mode  = mode_t'(req_lo_mode);
      req_in.split    = req_split;
      req_in.carry_in = req_carry_in;
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      carry_hold_d = carry_hold_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               req_d   = req_in;
               cnt_d   = CNT_LOAD;
               state_d = ST_STEP_A;
            end
         end
         ST_STEP_A: begin
            if (!last_cycle) begin
               cnt_d = cnt_q - STEP_CNT_W'(1);
            end else if (split_q) begin
               carry_hold_d = alu_carry_out;
               cnt_d        = CNT_LOAD;
               state_d      = ST_STEP_B;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STEP_B: begin
            if (!last_cycle) cnt_d = cnt_q - STEP_CNT_W'(1);
            else             state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      case (state_d)
         ST_STEP_A: phase_d = split_active(req_d) ? PH_LOW : PH_FULL;
         ST_STEP_B: phase_d = PH_HIGH;
         default:   phase_d = PH_IDLE;
      endcase
   end

   alu_pair_select_decode u_dec_hi (
      .pair      (req_d.hi_pair),
      .mode      (req_d.hi_mode),
      .phase     (phase_d),
      .not_sel_u (nsu_hi_d),
      .sel_l     (sl_hi_d),
      .sel_p     (sp_hi_d)
   );

   alu_pair_select_decode u_dec_lo (
      .pair      (req_d.lo_pair),
      .mode      (req_d.lo_mode),
      .phase     (phase_d),
      .not_sel_u (nsu_lo_d),
      .sel_l     (sl_lo_d),
      .sel_p     (sp_lo_d)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         req_q        <= '0;
         carry_hold_q <= 1'b0;
         notSel_U_hi  <= 3'b111;
         Sel_L_hi     <= 3'b000;
         Sel_P_hi     <= 3'b000;
         notSel_U_lo  <= 3'b111;
         Sel_L_lo     <= 3'b000;
         Sel_P_lo     <= 3'b000;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_q        <= req_d;
         carry_hold_q <= carry_hold_d;
         notSel_U_hi  <= nsu_hi_d;
         Sel_L_hi     <= sl_hi_d;
         Sel_P_hi     <= sp_hi_d;
         notSel_U_lo  <= nsu_lo_d;
         Sel_L_lo     <= sl_lo_d;
         Sel_P_lo     <= sp_lo_d;
      end
   end

   assign req_ready    = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign alu_carry_in = (state_q == ST_STEP_A) ? req_q.carry_in :
                         (state_q == ST_STEP_B) ? carry_hold_q : 1'b0;
   assign wb_lo        = (state_q == ST_STEP_A) && last_cycle;
   // An unsplit pair op writes both bytes at once. A split op writes the high byte after step B.
   assign wb_hi        = last_cycle &&
                         (((state_q == ST_STEP_A) && !split_q && has_pair_mode(req_q)) ||
                          (state_q == ST_STEP_B));

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       req_valid = 1'b0;
   logic [1:0] req_hi_pair = '0, req_hi_mode = '0, req_lo_pair = '0, req_lo_mode = '0;
   logic       req_split = 1'b0, req_carry_in = 1'b0, alu_carry_out = 1'b0;

   logic       req_ready, alu_carry_in, wb_lo, wb_hi, busy;
   logic [2:0] notSel_U_hi, Sel_L_hi, Sel_P_hi, notSel_U_lo, Sel_L_lo, Sel_P_lo;
   logic       req_ready_1, alu_carry_in_1, wb_lo_1, wb_hi_1, busy_1;
   logic [2:0] notSel_U_hi_1, Sel_L_hi_1, Sel_P_hi_1, notSel_U_lo_1, Sel_L_lo_1, Sel_P_lo_1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   alu_operand_sequencer #(.STEP_CYCLES(4)) dut (
      .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready),
      .req_hi_pair(req_hi_pair), .req_hi_mode(req_hi_mode),
      .req_lo_pair(req_lo_pair), .req_lo_mode(req_lo_mode),
      .req_split(req_split), .req_carry_in(req_carry_in),
      .alu_carry_out(alu_carry_out), .alu_carry_in(alu_carry_in),
      .notSel_U_hi(notSel_U_hi), .Sel_L_hi(Sel_L_hi), .Sel_P_hi(Sel_P_hi),
      .notSel_U_lo(notSel_U_lo), .Sel_L_lo(Sel_L_lo), .Sel_P_lo(Sel_P_lo),
      .wb_lo(wb_lo), .wb_hi(wb_hi), .busy(busy)
   );

   alu_operand_sequencer #(.STEP_CYCLES(1)) dut1 (
      .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready_1),
      .req_hi_pair(req_hi_pair), .req_hi_mode(req_hi_mode),
      .req_lo_pair(req_lo_pair), .req_lo_mode(req_lo_mode),
      .req_split(req_split), .req_carry_in(req_carry_in),
      .alu_carry_out(alu_carry_out), .alu_carry_in(alu_carry_in_1),
      .notSel_U_hi(notSel_U_hi_1), .Sel_L_hi(Sel_L_hi_1), .Sel_P_hi(Sel_P_hi_1),
      .notSel_U_lo(notSel_U_lo_1), .Sel_L_lo(Sel_L_lo_1), .Sel_P_lo(Sel_P_lo_1),
      .wb_lo(wb_lo_1), .wb_hi(wb_hi_1), .busy(busy_1)
   );

   // Observation vector: {hi selects(9), lo selects(9), carry, wb_lo, wb_hi, ready, busy}
   logic [22:0] obs4, obs1;
   assign obs4 = {notSel_U_hi, Sel_L_hi, Sel_P_hi, notSel_U_lo, Sel_L_lo, Sel_P_lo,
                  alu_carry_in, wb_lo, wb_hi, req_ready, busy};
   assign obs1 = {notSel_U_hi_1, Sel_L_hi_1, Sel_P_hi_1, notSel_U_lo_1, Sel_L_lo_1, Sel_P_lo_1,
                  alu_carry_in_1, wb_lo_1, wb_hi_1, req_ready_1, busy_1};

   localparam logic [22:0] IDLE_VEC = {3'b111, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000,
                                       1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   // Reference: which select lines one bus shows in a given step kind.
   // phase 0 idle, 1 whole op, 2 low half of split, 3 high half of split.
   function automatic logic [8:0] bus_model(input int pair, input int mode, input int phase);
      logic [2:0] oh;
      bit upper, lower, full;
      oh = (pair == 0 || mode == 0) ? 3'b000 : 3'(1 << (pair - 1));
      upper = 0; lower = 0; full = 0;
      if (phase == 1) begin
         upper = (mode == 1) || (mode == 3);
         lower = (mode == 2) || (mode == 3);
         full  = (mode == 3);
      end else if (phase == 2) begin
         upper = (mode == 1);
         lower = (mode != 1);
      end else if (phase == 3) begin
         upper = (mode == 3);
      end
      return {~(oh & {3{upper}}), oh & {3{lower}}, oh & {3{full}}};
   endfunction

   function automatic logic [22:0] exp_vec(input int hp, input int hm, input int lp, input int lm,
                                           input int ph, input bit cy, input bit wl, input bit wh,
                                           input bit bsy);
      return {bus_model(hp, hm, ph), bus_model(lp, lm, ph), cy, wl, wh, ~bsy, bsy};
   endfunction

   // Stimulus only: present one request for one edge (DUT assumed idle).
   task automatic send(input int hp, input int hm, input int lp, input int lm,
                       input bit sp, input bit ci);
      @(negedge CLK);
      req_hi_pair = 2'(hp); req_hi_mode = 2'(hm);
      req_lo_pair = 2'(lp); req_lo_mode = 2'(lm);
      req_split = sp; req_carry_in = ci; req_valid = 1'b1;
      @(posedge CLK);
      #1 req_valid = 1'b0;
   endtask

   task automatic test_reset;
      RESET = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         n_tests++;
         if (obs4 !== IDLE_VEC || obs1 !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL reset_hold got %h/%h want %h", obs4, obs1, IDLE_VEC);
         end
      end
      // A request presented in a reset cycle must not be taken.
      req_hi_pair = 2'd1; req_hi_mode = 2'd1; req_valid = 1'b1;
      @(negedge CLK);
      req_valid = 1'b0;
      n_tests++;
      if (obs4 !== IDLE_VEC) begin
         n_fail++;
         $display("FAIL reset_vs_req got %h want %h", obs4, IDLE_VEC);
      end
      RESET = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         n_tests++;
         if (obs4 !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL post_reset cyc%0d got %h want %h", c, obs4, IDLE_VEC);
         end
      end
   endtask

   task automatic test_byte_op;
      logic [22:0] e;
      send(1, 1, 2, 2, 0, 1);
      for (int c = 1; c <= 4; c++) begin
         @(negedge CLK);
         e = {3'b110, 3'b000, 3'b000, 3'b111, 3'b010, 3'b000, 1'b1, (c == 4), 1'b0, 1'b0, 1'b1};
         n_tests++;
         if (obs4 !== e) begin
            n_fail++;
            $display("FAIL byte_op cyc%0d got %h want %h", c, obs4, e);
         end
      end
      @(negedge CLK);
      n_tests++;
      if (obs4 !== IDLE_VEC) begin
         n_fail++;
         $display("FAIL byte_op_end got %h want %h", obs4, IDLE_VEC);
      end
   endtask

   task automatic test_split_add;
      logic [22:0] e;
      send(3, 3, 1, 3, 1, 0);
      for (int c = 1; c <= 8; c++) begin
         @(negedge CLK);
         if (c <= 4)
            e = {3'b111, 3'b100, 3'b000, 3'b111, 3'b001, 3'b000, 1'b0, (c == 4), 1'b0, 1'b0, 1'b1};
         else
            e = {3'b011, 3'b000, 3'b000, 3'b110, 3'b000, 3'b000, 1'b1, 1'b0, (c == 8), 1'b0, 1'b1};
         n_tests++;
         if (obs4 !== e) begin
            n_fail++;
            $display("FAIL split_add cyc%0d got %h want %h", c, obs4, e);
         end
         alu_carry_out = (c == 4);
      end
      alu_carry_out = 1'b0;
      @(negedge CLK);
      n_tests++;
      if (obs4 !== IDLE_VEC) begin
         n_fail++;
         $display("FAIL split_add_end got %h want %h", obs4, IDLE_VEC);
      end
   endtask

   task automatic test_unsplit_pair;
      logic [22:0] e;
      send(2, 3, 0, 0, 0, 0);
      for (int c = 1; c <= 4; c++) begin
         @(negedge CLK);
         e = {3'b101, 3'b010, 3'b010, 3'b111, 3'b000, 3'b000, 1'b0, (c == 4), (c == 4), 1'b0, 1'b1};
         n_tests++;
         if (obs4 !== e) begin
            n_fail++;
            $display("FAIL unsplit_pair cyc%0d got %h want %h", c, obs4, e);
         end
      end
      // split requested but no pair-mode operand: a single step, low write only
      send(1, 1, 3, 2, 1, 1);
      for (int c = 1; c <= 5; c++) begin
         @(negedge CLK);
         e = (c == 5) ? IDLE_VEC :
             {3'b110, 3'b000, 3'b000, 3'b111, 3'b100, 3'b000, 1'b1, (c == 4), 1'b0, 1'b0, 1'b1};
         n_tests++;
         if (obs4 !== e) begin
            n_fail++;
            $display("FAIL split_no_pair cyc%0d got %h want %h", c, obs4, e);
         end
      end
   endtask

   task automatic test_reset_mid_b;
      logic [22:0] e;
      send(3, 3, 1, 3, 1, 1);
      repeat (6) @(negedge CLK);   // now in STEP_B cycle 2
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      n_tests++;
      if (obs4 !== IDLE_VEC) begin
         n_fail++;
         $display("FAIL reset_mid_b got %h want %h", obs4, IDLE_VEC);
      end
      send(2, 1, 3, 2, 0, 0);
      @(negedge CLK);
      e = {3'b101, 3'b000, 3'b000, 3'b111, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      n_tests++;
      if (obs4 !== e) begin
         n_fail++;
         $display("FAIL after_reset_req got %h want %h", obs4, e);
      end
      repeat (4) @(negedge CLK);
      n_tests++;
      if (obs4 !== IDLE_VEC) begin
         n_fail++;
         $display("FAIL after_reset_end got %h want %h", obs4, IDLE_VEC);
      end
   endtask

   task automatic test_back_to_back;
      int hp[3] = '{1, 2, 3};
      int hm[3] = '{3, 1, 3};
      int lp[3] = '{0, 3, 2};
      int lm[3] = '{0, 2, 3};
      int r;
      logic [22:0] e;
      @(negedge CLK);
      req_hi_pair = 2'(hp[0]); req_hi_mode = 2'(hm[0]);
      req_lo_pair = 2'(lp[0]); req_lo_mode = 2'(lm[0]);
      req_split = 1'b0; req_carry_in = 1'b0; req_valid = 1'b1;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) @(negedge CLK);
         n_tests++;
         if (req_ready_1 !== (k % 2 == 0)) begin
            n_fail++;
            $display("FAIL b2b_ready k%0d got %b want %b", k, req_ready_1, (k % 2 == 0));
         end
         if (k % 2 == 1) begin
            r = k / 2;
            e = exp_vec(hp[r], hm[r], lp[r], lm[r], 1, r % 2, 1'b1, (hm[r] == 3 || lm[r] == 3), 1'b1);
            if (r < 2) begin
               req_hi_pair = 2'(hp[r+1]); req_hi_mode = 2'(hm[r+1]);
               req_lo_pair = 2'(lp[r+1]); req_lo_mode = 2'(lm[r+1]);
               req_carry_in = ((r + 1) % 2 == 1);
            end else begin
               req_valid = 1'b0;
            end
         end else begin
            e = IDLE_VEC;
         end
         n_tests++;
         if (obs1 !== e) begin
            n_fail++;
            $display("FAIL b2b_sel k%0d got %h want %h", k, obs1, e);
         end
         n_tests++;
         if ($countones(~notSel_U_hi_1 | Sel_L_hi_1 | Sel_P_hi_1) > 1 ||
             $countones(~notSel_U_lo_1 | Sel_L_lo_1 | Sel_P_lo_1) > 1) begin
            n_fail++;
            $display("FAIL b2b_overlap k%0d got %h want at most one pair per bus", k, obs1);
         end
      end
      repeat (10) @(negedge CLK);
   endtask

   task automatic test_random;
      int hp, hm, lp, lm, nsteps, ph;
      bit sp, ci, split_on, pair_op, co, cy;
      logic [22:0] e;
      for (int n = 0; n < 30; n++) begin
         hp = $urandom_range(0, 3); hm = $urandom_range(0, 3);
         lp = $urandom_range(0, 3); lm = $urandom_range(0, 3);
         sp = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
         pair_op  = (hp != 0 && hm == 3) || (lp != 0 && lm == 3);
         split_on = sp && pair_op;
         nsteps   = split_on ? 2 : 1;
         co = 1'b0;
         send(hp, hm, lp, lm, sp, ci);
         for (int s = 0; s < nsteps; s++) begin
            for (int c = 1; c <= 4; c++) begin
               @(negedge CLK);
               ph = !split_on ? 1 : (s == 0 ? 2 : 3);
               cy = (s == 0) ? ci : co;
               e = exp_vec(hp, hm, lp, lm, ph, cy, (s == 0 && c == 4),
                           (c == 4) && (s == 1 || (!split_on && pair_op)), 1'b1);
               n_tests++;
               if (obs4 !== e) begin
                  n_fail++;
                  $display("FAIL random op%0d step%0d cyc%0d got %h want %h", n, s, c, obs4, e);
               end
               alu_carry_out = 1'($urandom_range(0, 1));
               if (s == 0 && c == 4) co = alu_carry_out;
            end
         end
         repeat ($urandom_range(1, 3)) begin
            @(negedge CLK);
            n_tests++;
            if (obs4 !== IDLE_VEC) begin
               n_fail++;
               $display("FAIL random_idle op%0d got %h want %h", n, obs4, IDLE_VEC);
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_byte_op();
      test_split_add();
      test_unsplit_pair();
      test_reset_mid_b();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
